// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column scan, debounce, one strobe per accepted key.
// Optional auto-repeat while a key is held is enabled with macro KEYPAD_REPEAT_EN.
//
// state    | meaning
// SCAN     | drive columns in turn, look for a low row at the end of each dwell
// DEBOUNCE | columns frozen, row pattern must stay identical for DEBOUNCE_CNT cycles
// PRESSED  | key accepted and held; other keys ignored
// RELEASE  | rows all high; waiting for DEBOUNCE_CNT stable cycles before rescanning
module keypad_scan #(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 1000000,
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       rst_n,
    input  logic [3:0] rows_n,
    output logic [3:0] cols_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int MAX_AB = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
    localparam int MAX_CD = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int MAXP   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = ($clog2(MAXP) < 1) ? 1 : $clog2(MAXP);

    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_t;

    state_t        state;
    logic [3:0]    rows_m;
    logic [3:0]    rows_s;
    logic [1:0]    col;
    logic [1:0]    col_nx;
    logic [CW-1:0] cnt;
    logic [3:0]    lat_rows;
    logic [1:0]    lat_row;

    assign col_nx = col + 2'd1;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [3:0] col_drive(input logic [1:0] c);
        return ~(4'b0001 << c);
    endfunction

    function automatic logic [1:0] low_row(input logic [3:0] r);
        if (!r[0])      return 2'd0;
        else if (!r[1]) return 2'd1;
        else if (!r[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    // Row 3 carries '*' as E and '#' as F.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: return 4'h1;
            4'b00_01: return 4'h2;
            4'b00_10: return 4'h3;
            4'b00_11: return 4'hA;
            4'b01_00: return 4'h4;
            4'b01_01: return 4'h5;
            4'b01_10: return 4'h6;
            4'b01_11: return 4'hB;
            4'b10_00: return 4'h7;
            4'b10_01: return 4'h8;
            4'b10_10: return 4'h9;
            4'b10_11: return 4'hC;
            4'b11_00: return 4'hE;
            4'b11_01: return 4'h0;
            4'b11_10: return 4'hF;
            default:  return 4'hD;
        endcase
    endfunction

`ifdef KEYPAD_REPEAT_EN
    localparam logic [CW-1:0] DELAY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RATE_LAST  = CW'(REPEAT_RATE - 1);
    logic [CW-1:0] rcnt;
    logic          rep_armed;
    logic [CW-1:0] rep_last;
    assign rep_last = rep_armed ? RATE_LAST : DELAY_LAST;
`endif

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            rows_m    <= 4'hF;
            rows_s    <= 4'hF;
            state     <= SCAN;
            col       <= 2'd0;
            cnt       <= '0;
            cols_n    <= 4'b1110;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            lat_rows  <= 4'hF;
            lat_row   <= 2'd0;
`ifdef KEYPAD_REPEAT_EN
            rcnt      <= '0;
            rep_armed <= 1'b0;
`endif
        end else begin
            rows_m    <= rows_n;
            rows_s    <= rows_m;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == SCAN_LAST) begin
                        cnt <= '0;
                        if (rows_s != 4'hF) begin
                            lat_rows <= rows_s;
                            lat_row  <= low_row(rows_s);
                            state    <= DEBOUNCE;
                        end else begin
                            col    <= col_nx;
                            cols_n <= col_drive(col_nx);
                        end
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                DEBOUNCE: begin
                    if (rows_s != lat_rows) begin
                        state  <= SCAN;
                        col    <= col_nx;
                        cols_n <= col_drive(col_nx);
                        cnt    <= '0;
                    end else if (cnt == DEB_LAST) begin
                        key_code  <= key_map(lat_row, col);
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        state     <= PRESSED;
                        cnt       <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rcnt      <= '0;
                        rep_armed <= 1'b0;
`endif
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                PRESSED: begin
                    if (rows_s == 4'hF) begin
                        state <= RELEASE;
                        cnt   <= '0;
                    end
`ifdef KEYPAD_REPEAT_EN
                    else if (rcnt == rep_last) begin
                        key_valid <= 1'b1;
                        rcnt      <= '0;
                        rep_armed <= 1'b1;
                    end else begin
                        rcnt <= sat_inc(rcnt);
                    end
`endif
                end
                RELEASE: begin
                    // A bounce back to low rejoins PRESSED without a new strobe.
                    if (rows_s != 4'hF) begin
                        state <= PRESSED;
                        cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
                        rcnt      <= '0;
                        rep_armed <= 1'b0;
`endif
                    end else if (cnt == DEB_LAST) begin
                        state    <= SCAN;
                        key_held <= 1'b0;
                        col      <= col_nx;
                        cols_n   <= col_drive(col_nx);
                        cnt      <= '0;
                    end else begin
                        cnt <= sat_inc(cnt);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

endmodule
